// File: rtl/cpa_final_pipe_if.sv
// Valid/ready bundle between the compressor tree, the final adder and its consumer.
// The master side drives the rows and consumes the product; the slave is the adder.
interface cpa_final_pipe_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sum;
  logic [W-1:0] in_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_prod;
  logic         out_ovf;

  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_prod, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_prod, out_ovf
  );
endinterface

// File: rtl/cpa_final_pipe.sv
// Two-stage carry-propagate adder for the compressor-tree rows: stage 1 adds the low half,
// stage 2 adds the high half plus the low carry. Full backpressure, no bubbles.
module cpa_final_pipe #(
  parameter int W    = 16,
  parameter int LO_W = W / 2
) (
  input logic              clk,
  input logic              rst_n,
  cpa_final_pipe_if.slave  bus
);
  localparam int HI_W = W - LO_W;

  logic            s1_valid;
  logic            s2_valid;
  logic [LO_W-1:0] lo_sum;
  logic            lo_c;
  logic [HI_W-1:0] hi_s;
  logic [HI_W-1:0] hi_c;
  logic [W-1:0]    prod_q;
  logic            ovf_q;

  logic            s2_free;
  logic            s1_adv;
  logic            in_ready_c;
  logic            in_fire;
  logic [LO_W:0]   lo_add;
  logic [HI_W:0]   hi_add;

  // Ready ripples back combinationally so a full pipe can accept and emit on the same edge.
  always_comb begin
    s2_free    = !s2_valid || bus.out_ready;
    s1_adv     = s1_valid && s2_free;
    in_ready_c = !s1_valid || s2_free;
    in_fire    = bus.in_valid && in_ready_c;
    lo_add     = {1'b0, bus.in_sum[LO_W-1:0]} + {1'b0, bus.in_carry[LO_W-1:0]};
    hi_add     = {1'b0, hi_s} + {1'b0, hi_c} + {{HI_W{1'b0}}, lo_c};
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = s2_valid;
  assign bus.out_prod  = prod_q;
  assign bus.out_ovf   = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= in_fire | (s1_valid && !s2_free);
      s2_valid <= s1_adv | (s2_valid && !bus.out_ready);
    end
  end

  // Data registers only load on a transfer, so idle X on the inputs never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_sum <= '0;
      lo_c   <= 1'b0;
      hi_s   <= '0;
      hi_c   <= '0;
      prod_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (in_fire) begin
        lo_sum <= lo_add[LO_W-1:0];
        lo_c   <= lo_add[LO_W];
        hi_s   <= bus.in_sum[W-1:LO_W];
        hi_c   <= bus.in_carry[W-1:LO_W];
      end
      if (s1_adv) begin
        prod_q <= {hi_add[HI_W-1:0], lo_sum};
        ovf_q  <= hi_add[HI_W];
      end
    end
  end
endmodule

// File: tb/tb_cpa_final_pipe.sv
// Self-checking bench for cpa_final_pipe: directed vector table, reset, streaming,
// backpressure and random handshake phases against a sum+carry scoreboard.
module tb_cpa_final_pipe;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cpa_final_pipe_if #(.W(W)) bus();

  cpa_final_pipe #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic [W-1:0] carry;
    logic [W-1:0] prod;
    logic         ovf;
  } vec_t;

  vec_t         vecs [10];
  int           checks = 0;
  int           failures = 0;
  logic [W:0]   exp_q [$];
  bit           sb_on = 0;
  bit           stream_mode = 0;
  int           rcv = 0;
  int           cyc = 0;
  int           last_pop = 0;
  bit           hold_pending = 0;
  logic [W:0]   held;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] s, input logic [W-1:0] c);
    bus.in_sum   = s;
    bus.in_carry = c;
    bus.in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: decisions are made at the falling edge for the transfer on the next rising edge.
  always @(negedge clk) begin
    if (!sb_on) begin
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        checkOutput("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("hold_data", {15'd0, bus.out_ovf, bus.out_prod}, {15'd0, held});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_extra", {15'd0, bus.out_ovf, bus.out_prod}, 32'hFFFF_FFFF);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          checkOutput("sb_data", {15'd0, bus.out_ovf, bus.out_prod}, {15'd0, e});
        end
        if (stream_mode && rcv > 0) checkOutput("stream_gap", cyc, last_pop + 1);
        last_pop = cyc;
        rcv++;
      end
      hold_pending = bus.out_valid && !bus.out_ready;
      held = {bus.out_ovf, bus.out_prod};
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back({1'b0, bus.in_sum} + {1'b0, bus.in_carry});
      if (stream_mode && bus.in_valid) checkOutput("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
    end
  end

  task automatic wait_drain(input string name, input int target);
    for (int i = 0; i < 400; i++) begin
      if (rcv >= target) break;
      tick();
    end
    repeat (3) tick();
    checkOutput(name, rcv, target);
    checkOutput({name, "_empty"}, exp_q.size(), 0);
  endtask

  task automatic drive_items(input int n, input int pv, input int pr);
    int  sent;
    bit  fire;
    sent = 0;
    bus.in_sum    = 16'($urandom);
    bus.in_carry  = 16'($urandom);
    bus.in_valid  = ($urandom_range(99) < pv);
    bus.out_ready = ($urandom_range(99) < pr);
    while (sent < n) begin
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      tick();
      if (fire) sent++;
      if (fire || !bus.in_valid) begin
        bus.in_sum   = 16'($urandom);
        bus.in_carry = 16'($urandom);
        bus.in_valid = (sent < n) && ($urandom_range(99) < pv);
      end
      bus.out_ready = ($urandom_range(99) < pr);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int accepts;
    bit fire;

    vecs[0] = '{16'h00FF, 16'h0001, 16'h0100, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
    vecs[3] = '{16'h1234, 16'h4321, 16'h5555, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 16'h8000, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    vecs[6] = '{16'h80FF, 16'h7F01, 16'h0000, 1'b1};
    vecs[7] = '{16'hABCD, 16'h1111, 16'hBCDE, 1'b0};
    vecs[8] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[9] = '{16'h00F0, 16'h0010, 16'h0100, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_carry  = '0;
    bus.out_ready = 1'b1;

    #12;
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_out_prod", {16'd0, bus.out_prod}, 32'd0);
    checkOutput("rst_out_ovf", {31'd0, bus.out_ovf}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Directed table: output appears two edges after the row is presented.
    for (int v = 0; v < 10; v++) begin
      bus.out_ready = 1'b1;
      applyStimulus(vecs[v].sum, vecs[v].carry);
      tick();
      bus.in_valid = 1'b0;
      checkOutput($sformatf("vec%0d_early", v), {31'd0, bus.out_valid}, 32'd0);
      tick();
      checkOutput($sformatf("vec%0d_valid", v), {31'd0, bus.out_valid}, 32'd1);
      checkOutput($sformatf("vec%0d_prod", v), {16'd0, bus.out_prod}, {16'd0, vecs[v].prod});
      checkOutput($sformatf("vec%0d_ovf", v), {31'd0, bus.out_ovf}, {31'd0, vecs[v].ovf});
      tick();
    end

    // Reset mid-stream with a full, stalled pipe.
    bus.out_ready = 1'b0;
    applyStimulus(16'h0F0F, 16'h0101);
    tick();
    applyStimulus(16'h2222, 16'h3333);
    tick();
    bus.in_valid = 1'b0;
    tick();
    checkOutput("full_out_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("arst_out_prod", {16'd0, bus.out_prod}, 32'd0);
    checkOutput("arst_out_ovf", {31'd0, bus.out_ovf}, 32'd0);
    checkOutput("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    applyStimulus(16'h4321, 16'h1234);
    tick();
    bus.in_valid = 1'b0;
    tick();
    checkOutput("first_after_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("first_after_rst_prod", {16'd0, bus.out_prod}, 32'h5555);
    tick();
    checkOutput("no_stale_after_rst", {31'd0, bus.out_valid}, 32'd0);

    // Back-to-back streaming.
    sb_on = 1;
    stream_mode = 1;
    rcv = 0;
    drive_items(100, 100, 100);
    wait_drain("stream_count", 100);
    stream_mode = 0;

    // Backpressure: two rows fit, then the pipe must stall with stable output.
    rcv = 0;
    accepts = 0;
    bus.out_ready = 1'b0;
    applyStimulus(16'h00F0, 16'h0010);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      tick();
      if (fire) begin
        accepts++;
        applyStimulus(16'h00F0 + 16'(accepts * 16'h0101), 16'h0010);
      end
    end
    checkOutput("bp_accepts", accepts, 2);
    checkOutput("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    checkOutput("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("bp_out_prod", {16'd0, bus.out_prod}, 32'h0100);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      tick();
      if (fire) begin
        bus.in_valid = 1'b0;
        break;
      end
    end
    bus.in_valid = 1'b0;
    wait_drain("bp_drain", 3);

    // Random valid/ready toggling.
    rcv = 0;
    drive_items(1000, 50, 50);
    wait_drain("rand_count", 1000);
    sb_on = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
